// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU constants: divide-group opcodes, datapath width and
//           the divider state encoding.
// Rev     : 1.0
// ============================================================================
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_DIV  = 6'b010100;
    localparam logic [5:0] OP_DIVU = 6'b010101;
    localparam logic [5:0] OP_REM  = 6'b010110;
    localparam logic [5:0] OP_REMU = 6'b010111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One radix-2 restoring division step (combinational).
// Rev     : 1.0
// ============================================================================
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] d,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] q_next
);

    // One guard bit above the trial difference so the borrow is never lost.
    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_neg;

    assign w_shift = {rem, q[XLEN-1]};
    assign w_diff  = w_shift - {2'b00, d};
    assign w_neg   = w_diff[XLEN+1];

    always_comb begin
        rem_next = w_neg ? w_shift[XLEN:0] : w_diff[XLEN:0];
        q_next   = {q[XLEN-2:0], ~w_neg};
    end

endmodule
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
// Module  : alu_divider
// Brief   : Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per
//           cycle, with divide-by-zero and signed-overflow fast paths.
// Rev     : 1.0
// ============================================================================
module alu_divider #(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      ALUControl,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] resultALU
);

    import alu_pkg::*;

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_calc  = CALC;
    localparam logic [1:0] c_st_fixup = FIXUP;
    localparam logic [1:0] c_st_done  = DONE;

    localparam int            c_cnt_w   = $clog2(ITER);
    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]         r_state;
    logic [XLEN:0]      r_rem;
    logic [XLEN-1:0]    r_q;
    logic [XLEN-1:0]    r_d;
    logic [c_cnt_w-1:0] r_count;
    logic               r_is_rem;
    logic               r_qsign;
    logic               r_rsign;
    logic [XLEN-1:0]    r_result;

    logic               w_is_div;
    logic               w_is_signed;
    logic               w_is_rem;
    logic [XLEN-1:0]    w_abs1;
    logic [XLEN-1:0]    w_abs2;
    logic [XLEN:0]      w_rem_next;
    logic [XLEN-1:0]    w_q_next;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_remd;

    assign w_is_signed = (ALUControl == OP_DIV) || (ALUControl == OP_REM);
    assign w_is_rem    = (ALUControl == OP_REM) || (ALUControl == OP_REMU);
    assign w_is_div    = w_is_signed || (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);

    assign w_abs1 = (w_is_signed && operand1[XLEN-1]) ? -operand1 : operand1;
    assign w_abs2 = (w_is_signed && operand2[XLEN-1]) ? -operand2 : operand2;

    // Sign flags are only ever set for signed ops, so FIXUP needs no op check.
    assign w_quot = r_qsign ? -r_q : r_q;
    assign w_remd = r_rsign ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (r_rem),
        .q        (r_q),
        .d        (r_d),
        .rem_next (w_rem_next),
        .q_next   (w_q_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_rem    <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_count  <= '0;
            r_is_rem <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start && w_is_div && !flush) begin
                        r_is_rem <= w_is_rem;
                        if (operand2 == '0) begin
                            r_result <= w_is_rem ? operand1 : '1;
                            r_state  <= c_st_done;
                        end else if (w_is_signed && (operand1 == c_int_min) && (operand2 == '1)) begin
                            r_result <= w_is_rem ? '0 : c_int_min;
                            r_state  <= c_st_done;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= w_abs1;
                            r_d     <= w_abs2;
                            r_count <= c_cnt_w'(ITER - 1);
                            r_qsign <= w_is_signed && (operand1[XLEN-1] ^ operand2[XLEN-1]);
                            r_rsign <= w_is_signed && operand1[XLEN-1];
                            r_state <= c_st_calc;
                        end
                    end
                end
                c_st_calc: begin
                    if (flush) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_rem <= w_rem_next;
                        r_q   <= w_q_next;
                        if (r_count == '0) begin
                            r_state <= c_st_fixup;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                end
                c_st_fixup: begin
                    if (flush) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_result <= r_is_rem ? w_remd : w_quot;
                        r_state  <= c_st_done;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign resultALU = r_result;

endmodule
`default_nettype wire

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle iterative divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Sits beside the combinational ALU in the execute stage. The execute stage launches a divide with a one-cycle start pulse, stalls while busy is high, and takes the result on the done pulse through the writeback result mux.
- Radix-2 restoring algorithm: one quotient bit per cycle, with RISC-V divide-by-zero and overflow fast paths.

Parameters:
- XLEN, 32, operand/result width.
- ITER, XLEN, iteration count; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  launch request; sampled only in IDLE.
- ALUControl  in  6  operation code:
  - 6'b010100 DIV
  - 6'b010101 DIVU
  - 6'b010110 REM
  - 6'b010111 REMU
- operand1  in  XLEN  dividend; sampled with start.
- operand2  in  XLEN  divisor; sampled with start.
- flush  in  1  abort the in-flight operation (pipeline flush).
- busy  out  1  high from the cycle after start acceptance until done inclusive; pipeline stall source.
- done  out  1  one-cycle result-valid pulse.
- resultALU  out  XLEN  quotient or remainder; held until the next start is accepted.

Behaviour:
- Reset: rst_n sampled low at a rising edge gives:
  - state=IDLE; busy=0, done=0, resultALU=0.
  - Internal registers cleared.
  - Reset overrides start and flush, and aborts any operation in progress.
- States: IDLE, CALC, FIXUP, DONE.
- Start acceptance in IDLE:
  - start=1 with a non-divide ALUControl is ignored; stay in IDLE.
  - start=1 with a divide code latches op, operand1 and operand2, then:
    - divisor==0: go to DONE.
      - DIV/DIVU result = 32'hFFFFFFFF.
      - REM/REMU result = operand1.
    - Signed op with operand1==32'h80000000 and operand2==32'hFFFFFFFF: go to DONE.
      - DIV result = 32'h80000000.
      - REM result = 0.
    - Otherwise go to CALC with count=ITER-1.
      - Signed ops latch |operand1| and |operand2|, plus quotient sign (s1^s2) and remainder sign (s1).
      - Unsigned ops latch the operands as-is.
- CALC, one step per cycle, using an XLEN+1 bit remainder register rem, quotient/dividend shift register q, and divisor d:
  - Compute t = {rem[XLEN-1:0], q[XLEN-1]} - {1'b0, d}.
  - If t is negative: rem = {rem[XLEN-1:0], q[XLEN-1]}, shift a 0 into q.
  - Else: rem = t, shift a 1 into q.
  - Decrement count. When count==0, the step completes and the state goes to FIXUP.
- FIXUP:
  - Negate the quotient if its sign bit is set (signed DIV only).
  - Negate the remainder if the dividend was negative (signed REM only).
  - Load resultALU with the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored; the requester must re-assert it in IDLE.
- Latency, counting the start edge as cycle 0:
  - Normal operation: done high in cycle ITER+2 (34).
  - Fast paths: done high in cycle 1.
- busy: high in CALC, FIXUP and DONE; low in IDLE.
- flush:
  - In CALC or FIXUP: state goes to IDLE next cycle, no done, resultALU unchanged.
  - In DONE: done still completes (the result is already produced).
  - In IDLE: flush wins over a simultaneous start; nothing is latched.
- Operand changes after acceptance have no effect.
- Arithmetic is XLEN bits modulo 2^XLEN. Negating 32'h80000000 yields 32'h80000000, which is correct as an unsigned magnitude.

Decomposition:
- Package alu_pkg holds:
  - ALUControl constants OP_DIV, OP_DIVU, OP_REM, OP_REMU. The combinational ALU imports the same constants.
  - XLEN.
  - div_state_t enum {IDLE, CALC, FIXUP, DONE}.
- One combinational sub-module div_step: one restoring step, with inputs (rem, q, d) and outputs (rem_next, q_next). It can be unit-tested standalone.

Test Plan:
- DIVU 100/7 with start pulse -> busy high in cycles 1..34, done at cycle 34, resultALU=14; REMU on the same operands -> 2.
- DIV -7/2 -> 32'hFFFFFFFD (-3); REM -7/2 -> 32'hFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
- DIVU 32'hFFFFFFFF/2 -> 32'h7FFFFFFF; DIVU 5/32'hFFFFFFFF -> 0; REMU 5/32'hFFFFFFFF -> 5.
- Divide by zero: DIV 42/0 -> 32'hFFFFFFFF; REM 42/0 -> 42; in both cases done at cycle 1.
- Overflow: DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000; REM on the same operands -> 0; done at cycle 1.
- Abort cases:
  - flush asserted in cycle 10 -> busy low in cycle 11, done never pulses, prior resultALU retained.
  - rst_n low mid-CALC -> all outputs 0 next cycle.
  - start with ALUControl=6'b000010 (ADD) -> ignored, busy stays 0.
